// File: rtl/ram32m_fifo_pkg.sv
// Shared constants and types for the RAM32M-based FIFO controller.
package ram32m_fifo_pkg;

  localparam int FIFO_DEPTH = 32;
  localparam int PTR_W      = 5;
  localparam int DATA_W     = 6;
  localparam int LEVEL_W    = 6;

  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [LEVEL_W-1:0] level_t;

  localparam level_t RAM_FULL = level_t'(FIFO_DEPTH);

endpackage

// File: rtl/ram32m_fifo_ctrl_ram32m.sv
// Behavioural model of the RAM32M distributed-RAM primitive:
// 32 x 2-bit x 4 ports, one shared write address (ADDRD), asynchronous reads.
// INIT_* are accepted for drop-in compatibility; contents power up undefined here.
module RAM32M #(
  parameter logic [63:0] INIT_A           = 64'h0,
  parameter logic [63:0] INIT_B           = 64'h0,
  parameter logic [63:0] INIT_C           = 64'h0,
  parameter logic [63:0] INIT_D           = 64'h0,
  parameter logic        IS_WCLK_INVERTED = 1'b0
) (
  output logic [1:0] DOA,
  output logic [1:0] DOB,
  output logic [1:0] DOC,
  output logic [1:0] DOD,
  input  logic [4:0] ADDRA,
  input  logic [4:0] ADDRB,
  input  logic [4:0] ADDRC,
  input  logic [4:0] ADDRD,
  input  logic [1:0] DIA,
  input  logic [1:0] DIB,
  input  logic [1:0] DIC,
  input  logic [1:0] DID,
  input  logic       WCLK,
  input  logic       WE
);

  logic [1:0] mem_a [32];
  logic [1:0] mem_b [32];
  logic [1:0] mem_c [32];
  logic [1:0] mem_d [32];
  logic       wclk_int;
  logic       unused_init;

  assign wclk_int    = WCLK ^ IS_WCLK_INVERTED;
  assign unused_init = ^{INIT_A, INIT_B, INIT_C, INIT_D};

  // All four arrays are written together at the port-D address.
  always_ff @(posedge wclk_int) begin
    if (WE) begin
      mem_a[ADDRD] <= DIA;
      mem_b[ADDRD] <= DIB;
      mem_c[ADDRD] <= DIC;
      mem_d[ADDRD] <= DID;
    end
  end

  assign DOA = mem_a[ADDRA];
  assign DOB = mem_b[ADDRB];
  assign DOC = mem_c[ADDRC];
  assign DOD = mem_d[ADDRD];

endmodule

// File: rtl/ram32m_fifo_ctrl.sv
// Single-clock FIFO controller around one RAM32M (32 x 6 bit) with a
// registered first-word-fall-through output stage; capacity 33 words.
// Optional macro RAM32M_FIFO_AFULL_EN builds the ALMOST_FULL flag
// (LEVEL >= AFULL_LEVEL); without it ALMOST_FULL is tied low.
module ram32m_fifo_ctrl
  import ram32m_fifo_pkg::*;
#(
  parameter logic [63:0] INIT_A      = 64'h0,
  parameter logic [63:0] INIT_B      = 64'h0,
  parameter logic [63:0] INIT_C      = 64'h0,
  parameter int          AFULL_LEVEL = 30
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic [DATA_W-1:0] I_DATA,
  input  logic              I_VALID,
  output logic              I_READY,
  output logic [DATA_W-1:0] O_DATA,
  output logic              O_VALID,
  input  logic              O_READY,
  output logic [LEVEL_W-1:0] LEVEL,
  output logic              ALMOST_FULL
);

  ptr_t              wr_ptr, wr_ptr_nxt;
  ptr_t              rd_ptr, rd_ptr_nxt;
  level_t            ram_cnt, ram_cnt_nxt;
  level_t            level_q, level_nxt;
  logic [DATA_W-1:0] o_data_q, o_data_nxt;
  logic              o_valid_q, o_valid_nxt;
  logic [DATA_W-1:0] ram_dout;
  logic [1:0]        dod_unused;
  logic              wr_fire;
  logic              load;

  // Ready depends only on registered occupancy, never on O_READY.
  assign I_READY = (ram_cnt != RAM_FULL);
  assign wr_fire = I_VALID && I_READY;
  assign load    = (ram_cnt != '0) && (!o_valid_q || O_READY);

  RAM32M #(
    .INIT_A           (INIT_A),
    .INIT_B           (INIT_B),
    .INIT_C           (INIT_C),
    .INIT_D           (64'h0),
    .IS_WCLK_INVERTED (1'b0)
  ) u_ram (
    .DOA   (ram_dout[1:0]),
    .DOB   (ram_dout[3:2]),
    .DOC   (ram_dout[5:4]),
    .DOD   (dod_unused),
    .ADDRA (rd_ptr),
    .ADDRB (rd_ptr),
    .ADDRC (rd_ptr),
    .ADDRD (wr_ptr),
    .DIA   (I_DATA[1:0]),
    .DIB   (I_DATA[3:2]),
    .DIC   (I_DATA[5:4]),
    .DID   (2'b00),
    .WCLK  (CLK),
    .WE    (wr_fire)
  );

  // Next-state for pointers, occupancy and the output stage; FLUSH wins.
  always_comb begin
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    ram_cnt_nxt = ram_cnt;
    o_data_nxt  = o_data_q;
    o_valid_nxt = o_valid_q;
    if (FLUSH) begin
      wr_ptr_nxt  = '0;
      rd_ptr_nxt  = '0;
      ram_cnt_nxt = '0;
      o_valid_nxt = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_nxt = wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr_nxt  = rd_ptr + 1'b1;
        o_data_nxt  = ram_dout;
        o_valid_nxt = 1'b1;
      end else if (o_valid_q && O_READY) begin
        o_valid_nxt = 1'b0;
      end
      case ({wr_fire, load})
        2'b10:   ram_cnt_nxt = ram_cnt + 1'b1;
        2'b01:   ram_cnt_nxt = ram_cnt - 1'b1;
        default: ram_cnt_nxt = ram_cnt;
      endcase
    end
    level_nxt = ram_cnt_nxt + level_t'(o_valid_nxt);
  end

  // State register; async reset empties the FIFO without a clock.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      level_q   <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      ram_cnt   <= ram_cnt_nxt;
      level_q   <= level_nxt;
      o_data_q  <= o_data_nxt;
      o_valid_q <= o_valid_nxt;
    end
  end

  assign O_DATA  = o_data_q;
  assign O_VALID = o_valid_q;
  assign LEVEL   = level_q;

`ifdef RAM32M_FIFO_AFULL_EN
  logic afull_q;
  logic unused_dod;

  assign unused_dod = ^dod_unused;

  // Flag tracks next-state LEVEL so it changes on the same edge as LEVEL.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      afull_q <= 1'b0;
    end else if (FLUSH) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= (level_nxt >= level_t'(AFULL_LEVEL));
    end
  end

  assign ALMOST_FULL = afull_q;
`else
  logic unused_cfg;

  assign unused_cfg  = ^{dod_unused, AFULL_LEVEL};
  assign ALMOST_FULL = 1'b0;
`endif

endmodule

// File: tb/tb_ram32m_fifo_ctrl.sv
// Self-checking bench for ram32m_fifo_ctrl with an output-order scoreboard.
module tb_ram32m_fifo_ctrl;

  localparam int AFULL = 30;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       FLUSH;
  logic [5:0] I_DATA;
  logic       I_VALID;
  logic       I_READY;
  logic [5:0] O_DATA;
  logic       O_VALID;
  logic       O_READY;
  logic [5:0] LEVEL;
  logic       ALMOST_FULL;

  int checks = 0;
  int errors = 0;

  logic [5:0] q[$];
  int         m_cnt;
  bit         m_ov;

  ram32m_fifo_ctrl #(
    .INIT_A      (64'h0),
    .INIT_B      (64'h0),
    .INIT_C      (64'h0),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .FLUSH       (FLUSH),
    .I_DATA      (I_DATA),
    .I_VALID     (I_VALID),
    .I_READY     (I_READY),
    .O_DATA      (O_DATA),
    .O_VALID     (O_VALID),
    .O_READY     (O_READY),
    .LEVEL       (LEVEL),
    .ALMOST_FULL (ALMOST_FULL)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit exp_afull();
`ifdef RAM32M_FIFO_AFULL_EN
    return q.size() >= AFULL;
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive inputs, check pre-edge state, update model, check post-edge.
  task automatic cycle(input bit vin, input logic [5:0] din, input bit rdy, input bit fl);
    bit fire, ld, pop;
    logic [5:0] exp_d;
    I_VALID = vin;
    I_DATA  = din;
    O_READY = rdy;
    FLUSH   = fl;
    checks++;
    if (I_READY !== (m_cnt != 32)) begin
      errors++;
      $display("FAIL i_ready: got %b want %b", I_READY, (m_cnt != 32));
    end
    fire = vin && (m_cnt != 32);
    ld   = (m_cnt != 0) && (!m_ov || rdy);
    pop  = m_ov && rdy;
    if (fl) begin
      q.delete();
      m_cnt = 0;
      m_ov  = 1'b0;
    end else begin
      if (pop) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow: got O_DATA %h with nothing expected", O_DATA);
        end else begin
          exp_d = q.pop_front();
          if (O_DATA !== exp_d) begin
            errors++;
            $display("FAIL o_data_order: got %h want %h", O_DATA, exp_d);
          end
        end
      end
      if (fire) q.push_back(din);
      m_cnt = m_cnt + (fire ? 1 : 0) - (ld ? 1 : 0);
      if (ld) m_ov = 1'b1;
      else if (pop) m_ov = 1'b0;
    end
    @(posedge CLK);
    #1;
    checks++;
    if (O_VALID !== m_ov) begin
      errors++;
      $display("FAIL o_valid: got %b want %b", O_VALID, m_ov);
    end
    checks++;
    if (LEVEL !== 6'(q.size())) begin
      errors++;
      $display("FAIL level: got %0d want %0d", LEVEL, q.size());
    end
    checks++;
    if (ALMOST_FULL !== exp_afull()) begin
      errors++;
      $display("FAIL almost_full: got %b want %b (level %0d)", ALMOST_FULL, exp_afull(), q.size());
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || O_VALID !== 1'b0) && n < 100) begin
      cycle(1'b0, 6'h00, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (q.size() != 0 || O_VALID !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: O_VALID %b, %0d words still expected", O_VALID, q.size());
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; FLUSH = 1'b0; I_VALID = 1'b0; I_DATA = '0; O_READY = 1'b0;
    q.delete(); m_cnt = 0; m_ov = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (I_READY !== 1'b1 || O_VALID !== 1'b0 || O_DATA !== 6'h00 ||
        LEVEL !== 6'd0 || ALMOST_FULL !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got rdy %b vld %b data %h lvl %0d af %b want 1 0 00 0 0",
               I_READY, O_VALID, O_DATA, LEVEL, ALMOST_FULL);
    end
  endtask

  task automatic test_single_write();
    cycle(1'b1, 6'h2A, 1'b0, 1'b0);
    cycle(1'b0, 6'h00, 1'b0, 1'b0);
    checks++;
    if (O_VALID !== 1'b1 || O_DATA !== 6'h2A || LEVEL !== 6'd1) begin
      errors++;
      $display("FAIL single_write: got vld %b data %h lvl %0d want 1 2a 1", O_VALID, O_DATA, LEVEL);
    end
    drain();
  endtask

  task automatic test_fill();
    int acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (I_READY === 1'b1) acc++;
      cycle(1'b1, 6'(i), 1'b0, 1'b0);
    end
    checks++;
    if (acc != 33 || LEVEL !== 6'd33 || I_READY !== 1'b0) begin
      errors++;
      $display("FAIL fill: got accepted %0d lvl %0d rdy %b want 33 33 0", acc, LEVEL, I_READY);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [5:0] lvl0;
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'(50 + i), 1'b0, 1'b0);
    cycle(1'b0, 6'h00, 1'b0, 1'b0);
    lvl0 = LEVEL;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 6'(i), 1'b1, 1'b0);
      checks++;
      if (LEVEL !== lvl0) begin
        errors++;
        $display("FAIL steady_level: got %0d want %0d at cycle %0d", LEVEL, lvl0, i);
      end
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cycle(1'b1, 6'(10 + i), 1'b0, 1'b0);
    cycle(1'b0, 6'h00, 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 6'd5) begin
      errors++;
      $display("FAIL flush_setup: got level %0d want 5", LEVEL);
    end
    cycle(1'b1, 6'h3F, 1'b1, 1'b1);
    checks++;
    if (LEVEL !== 6'd0 || O_VALID !== 1'b0 || I_READY !== 1'b1) begin
      errors++;
      $display("FAIL flush: got lvl %0d vld %b rdy %b want 0 0 1", LEVEL, O_VALID, I_READY);
    end
    cycle(1'b0, 6'h00, 1'b0, 1'b0);
    cycle(1'b0, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 6'(20 + i), 1'b0, 1'b0);
    cycle(1'b0, 6'h00, 1'b0, 1'b0);
    checks++;
    if (LEVEL !== 6'd10) begin
      errors++;
      $display("FAIL areset_setup: got level %0d want 10", LEVEL);
    end
    I_VALID = 1'b0; O_READY = 1'b0; FLUSH = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if (I_READY !== 1'b1 || O_VALID !== 1'b0 || O_DATA !== 6'h00 ||
        LEVEL !== 6'd0 || ALMOST_FULL !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rdy %b vld %b data %h lvl %0d af %b want 1 0 00 0 0",
               I_READY, O_VALID, O_DATA, LEVEL, ALMOST_FULL);
    end
    #1 RST_N = 1'b1;
    q.delete(); m_cnt = 0; m_ov = 1'b0;
    @(posedge CLK);
    #1;
    cycle(1'b1, 6'h15, 1'b0, 1'b0);
    cycle(1'b0, 6'h00, 1'b0, 1'b0);
    checks++;
    if (O_VALID !== 1'b1 || O_DATA !== 6'h15) begin
      errors++;
      $display("FAIL post_reset_write: got vld %b data %h want 1 15", O_VALID, O_DATA);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram32m_fifo_ctrl.md
# ram32m_fifo_ctrl

Synchronous FIFO controller built around one RAM32M distributed-RAM primitive used as 32 × 6-bit storage. It owns the write pointer (driven on ADDRD), the read pointer (driven on ADDRA/ADDRB/ADDRC), and a registered first-word-fall-through output stage. Occupancy, full and empty tracking are all handled here. Used as the small elastic buffer between single-clock streaming stages, where a block RAM would be wasteful.

## Interface
Parameters:
- INIT_A/INIT_B/INIT_C, 64'h0 — passed to the RAM32M instance; contents are otherwise don't-care.
- AFULL_LEVEL, 30 — threshold for ALMOST_FULL (range 1..33); only used when the macro is defined.

Ports:
- CLK  in  1  — single clock; all logic is rising-edge.
- RST_N  in  1  — asynchronous, active-low reset.
- FLUSH  in  1  — synchronous clear of all FIFO state.
- I_DATA  in  6  — write data; bits [1:0]→DIA, [3:2]→DIB, [5:4]→DIC. DID is tied to 2'b00.
- I_VALID  in  1  — write request.
- I_READY  out  1  — FIFO can accept a write; equals (ram_cnt != 32).
- O_DATA  out  6  — registered head-of-FIFO data.
- O_VALID  out  1  — O_DATA holds a valid entry.
- O_READY  in  1  — consumer accepts O_DATA.
- LEVEL  out  6  — total entries held, counting RAM plus output register (0..33).
- ALMOST_FULL  out  1  — see Configuration.

## Operation
- Write fires when I_VALID && I_READY. At the edge: RAM[wr_ptr] ← I_DATA, wr_ptr ← wr_ptr+1 (5-bit, wraps 31→0), ram_cnt increments.
- RAM32M is instanced with WE = write-fire, ADDRD = wr_ptr, ADDRA = ADDRB = ADDRC = rd_ptr, IS_WCLK_INVERTED = 0. DOD is unused.
- Load condition: ram_cnt != 0 && (!O_VALID || O_READY). On a load, at the edge: O_DATA ← {DOC, DOB, DOA}, O_VALID ← 1, rd_ptr ← rd_ptr+1 (wraps), ram_cnt decrements.
- Pop without load: when O_VALID && O_READY && ram_cnt == 0, then O_VALID ← 0 and O_DATA holds its value.
- Simultaneous write and load: ram_cnt is unchanged and both pointers advance.
- LEVEL = ram_cnt + O_VALID, registered and updated in the same edge as the underlying state.
- There is no write-to-read bypass. A word written into an empty FIFO becomes readable from the RAM only on the following cycle.
- Reads only ever address occupied entries, so a read never aliases the entry being written.
- Full: when ram_cnt == 32, I_READY = 0 and writes are ignored. Total capacity is 33 entries (32 in RAM, 1 in the output register).
- Empty: when O_VALID = 0, O_READY is ignored.
- FLUSH has priority over write and load in the same cycle. It clears the pointers, ram_cnt, LEVEL and O_VALID. RAM contents are not cleared.

## Timing
- Reset values: I_READY = 1, O_VALID = 0, O_DATA = 6'h00, LEVEL = 0, ALMOST_FULL = 0. Both pointers and ram_cnt reset to 0.
- RST_N assertion mid-operation empties the FIFO immediately, without waiting for a clock edge. RAM contents are retained but unreachable.
- Write-to-output latency into an empty FIFO is 2 edges: write at edge N, O_VALID high after edge N+1.
- Throughput is one write and one read per cycle, sustained.
- I_READY is a combinational decode of the registered ram_cnt. It has no combinational path from O_READY.
- O_DATA and O_VALID are registered outputs.

## Configuration
- Macro RAM32M_FIFO_AFULL_EN.
- Defined: ALMOST_FULL is a registered flag that is high when LEVEL ≥ AFULL_LEVEL, evaluated on next-state LEVEL so it has no lag. It clears on reset and on FLUSH.
- Undefined: ALMOST_FULL is tied to 0, no comparator logic is built, and AFULL_LEVEL is ignored. The port list is identical in both builds.

## Structure
- Package ram32m_fifo_pkg holds the shared constants:
  - FIFO_DEPTH = 32
  - PTR_W = 5
  - DATA_W = 6
  - LEVEL_W = 6
  - typedef ptr_t (logic [PTR_W-1:0])
  - typedef level_t (logic [LEVEL_W-1:0])
- The only sub-module is a single RAM32M instance (u_ram). The pointer, count and output-stage logic stays flat in ram32m_fifo_ctrl.

## Test plan
- Reset then single write: write 6'h2A at edge 1 with O_READY = 0. Expect O_VALID = 1 and O_DATA = 6'h2A after edge 2, LEVEL = 1.
- Fill: 40 back-to-back writes of 0..39 with O_READY = 0. Expect I_READY to drop after 33 accepted writes and LEVEL = 33. Then drain with O_READY = 1 and expect the outputs 0..32 in order, then O_VALID = 0.
- Wrap-around: 100 cycles of concurrent write and read at steady state with data = cycle index. Expect in-order output with no gaps and constant LEVEL.
- Simultaneous FLUSH + write + O_READY with LEVEL = 5. Expect LEVEL = 0, O_VALID = 0 and I_READY = 1 after the edge. The write is discarded.
- Async reset pulse mid-stream: RST_N low between edges with LEVEL = 10. Expect outputs at reset values immediately. The next write 6'h15 appears after 2 edges.
- Macro build, AFULL_LEVEL = 30: ALMOST_FULL rises on the edge LEVEL reaches 30 and falls on the edge it drops to 29. Without the macro, ALMOST_FULL stays 0 throughout the fill test.
